// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : RV32I fetch-stage program counter with stall, redirect, trap, halt
// Revision : 1.0
// ============================================================================
module pc_unit #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          IALIGN       = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            fetch_valid_o,
    output logic            flush_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] misaligned_addr_o,
    output logic [31:0]     fetch_count_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] C_RESET_PC   = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0] C_TRAP_PC    = XLEN'(TRAP_VECTOR);
    localparam logic [XLEN-1:0] C_STEP       = XLEN'(IALIGN);
    localparam logic [XLEN-1:0] C_ALIGN_MASK = XLEN'(IALIGN - 1);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;
    logic [31:0]     count_q, count_d;

    logic [XLEN-1:0] w_pc_plus;
    logic            w_run;
    logic            w_accept;
    logic            w_target_misaligned;

    assign w_pc_plus           = pc_q + C_STEP;
    assign w_run               = (state_q == ST_RUN);
    assign w_accept            = w_run && fetch_ready_i && !stall_i;
    assign w_target_misaligned = |(redirect_target_i & C_ALIGN_MASK);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        mis_d      = mis_q;
        mis_addr_d = mis_addr_q;
        count_d    = count_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // The fetch presented this cycle counts even if it is abandoned
                if (w_accept) begin
                    count_d = count_q + 32'd1;
                end
                if (trap_valid_i) begin
                    pc_d    = C_TRAP_PC;
                    flush_d = 1'b1;
                end else if (redirect_valid_i) begin
                    flush_d = 1'b1;
                    if (w_target_misaligned) begin
                        state_d    = ST_HALT;
                        mis_d      = 1'b1;
                        mis_addr_d = redirect_target_i;
                    end else begin
                        pc_d = redirect_target_i;
                    end
                end else if (!stall_i && fetch_ready_i) begin
                    pc_d = w_pc_plus;
                end
            end

            ST_HALT: begin
                if (trap_valid_i) begin
                    pc_d    = C_TRAP_PC;
                    mis_d   = 1'b0;
                    flush_d = 1'b1;
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_BOOT;
            pc_q       <= C_RESET_PC;
            flush_q    <= 1'b0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
            count_q    <= count_d;
        end
    end

    assign pc_o              = pc_q;
    assign pc_plus_o         = w_pc_plus;
    assign fetch_valid_o     = w_run;
    assign flush_o           = flush_q;
    assign misaligned_o      = mis_q;
    assign misaligned_addr_o = mis_addr_q;
    assign fetch_count_o     = count_q;

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RV32I pipelined core, sitting at the head of the fetch stage and driving the instruction-memory address. It extends the plain PC register with a configurable reset and trap vector, stall and backpressure hold, branch/jump redirect, trap redirect, misaligned-target detection with a halt state, a one-cycle flush pulse to the pipeline, and a fetch counter.

## Interface
- XLEN, 32: PC and address width.
- RESET_VECTOR, 32'h0000_0000: PC value while reset is asserted and in BOOT.
- TRAP_VECTOR, 32'h0000_0100: PC loaded on trap.
- IALIGN, 4: instruction alignment and sequential increment in bytes. Legal values are 2 and 4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard hold from decode; PC does not advance.
- fetch_ready  in  1  instruction memory accepts the current address.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  branch/jump target address.
- trap_valid  in  1  exception or trap entry request.
- pc  out  XLEN  current fetch address; registered.
- pc_plus  out  XLEN  pc + IALIGN, combinational from pc, modulo 2^XLEN.
- fetch_valid  out  1  pc is a valid fetch request; high only in RUN.
- flush  out  1  registered one-cycle pulse after an accepted redirect or trap.
- misaligned  out  1  sticky misaligned-target flag.
- misaligned_addr  out  XLEN  offending target address, captured when misaligned is set.
- fetch_count  out  32  number of accepted fetches; wraps modulo 2^32.

## Operation
- State machine has three states: BOOT, RUN, HALT. Encoding is free.
- Reset values: state=BOOT, pc=RESET_VECTOR, flush=0, misaligned=0, misaligned_addr=0, fetch_count=0.
- BOOT:
  - Lasts exactly one cycle after reset deasserts.
  - fetch_valid=0; all inputs are ignored; pc is held.
  - Next state is RUN.
- RUN: fetch_valid=1. Per-cycle priority, highest first:
  - trap_valid: pc←TRAP_VECTOR, flush←1.
  - redirect_valid with aligned target, i.e. redirect_target mod IALIGN == 0: pc←redirect_target, flush←1. Redirect overrides stall and !fetch_ready; the outstanding request is abandoned.
  - redirect_valid with misaligned target: state←HALT, misaligned←1, misaligned_addr←redirect_target, flush←1, pc held.
  - stall or !fetch_ready: pc held.
  - Otherwise pc←pc+IALIGN, wrapping modulo 2^XLEN.
- An accepted fetch is a cycle with fetch_valid && fetch_ready && !stall. fetch_count increments by 1 on each accepted fetch, in any priority case including trap and redirect.
- HALT:
  - fetch_valid=0; stall, fetch_ready and redirect are ignored; pc is held.
  - trap_valid: pc←TRAP_VECTOR, misaligned←0, flush←1, state←RUN. misaligned_addr keeps its value.
- Handshake rule: while fetch_valid=1 and fetch_ready=0, pc is stable unless trap or redirect is accepted.
- flush is high for exactly one cycle per accepted event. Back-to-back events give a continuous high.

## Timing
- All state changes on the rising clk edge. reset acts immediately, with no clock required.
- Reset asserted mid-operation forces all outputs to their reset values within the same cycle. BOOT follows release.
- Redirect or trap sampled at edge N: pc=new value and flush=1 after edge N, so the target is fetched in the next cycle.
- Sequential advance latency is one cycle per accepted fetch.
- pc_plus and fetch_valid are combinational from registered state and glitch-free with respect to the inputs.

## Test plan
Defaults for all scenarios unless stated: XLEN=32, RESET_VECTOR=0, TRAP_VECTOR=0x100, IALIGN=4.
- Reset then fetch_ready=1, stall=0: one BOOT cycle with fetch_valid=0 and pc=0, then pc=0,4,8,12,16 on successive cycles; fetch_count=1,2,3,4 after each step. With RESET_VECTOR=0xFFFF_FFF8: pc=0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Hold at pc=8, stall=1 for 2 cycles then fetch_ready=0 for 2 cycles: pc stays 8 and fetch_count unchanged for 4 cycles, then pc=12.
- redirect_valid=1 with target 0x40 and stall=1 at pc=12: next cycle pc=0x40 and flush=1 for exactly one cycle, then pc=0x44.
- trap_valid=1 and redirect_valid=1 (target 0x40) in the same cycle: pc=0x100, flush=1 for one cycle.
- Redirect to 0x42: state HALT, fetch_valid=0, misaligned=1, misaligned_addr=0x42, pc held. A later redirect to 0x80 is ignored. Then trap_valid=1: pc=0x100, misaligned=0, fetch_valid=1.
- Async reset asserted between edges at pc=0x20: pc=0, fetch_valid=0, fetch_count=0 before the next edge. After release: one BOOT cycle, then pc=0,4,...
